sub_arbiter: RTL and testbench

Round-robin arbiter sharing one WIDTH-bit subtractor among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The winner's difference is registered into a single output slot with its requester ID and held until the consumer accepts it. The block sits between the SPI-side command decoders and the shared arithmetic datapath, replacing direct hard-wiring of the subtractor.

---
 rtl/sub_arb_pkg.sv | 34 +++
 rtl/sub_arbiter_if.sv | 61 ++++++
 rtl/sub_unit.sv | 25 ++
 rtl/sub_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sub_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sub_arb_pkg.sv
// -----------------------------------------------------------------------------
// sub_arb_pkg
// Shared constants, types and helpers for the round-robin subtractor arbiter.
//   NUM_REQ_DEF / WIDTH_DEF : default requester count and datapath width
//   slot_state_t            : occupancy of the single output slot
//   clog2 / id_width        : width of the requester-id field
// -----------------------------------------------------------------------------
package sub_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 8;

    // EMPTY: slot free; FULL: slot holds a result the consumer has not taken.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Ceiling log2 for elaboration-time width computation.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Id field is never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

endpackage : sub_arb_pkg

// File: rtl/sub_arbiter_if.sv
// -----------------------------------------------------------------------------
// sub_arbiter_if
// Bundles the requester and consumer handshakes of sub_arbiter.
//   req_valid  [NUM_REQ]        requester i presents operands
//   req_a/b    [NUM_REQ*WIDTH]  operands, requester i in [i*WIDTH +: WIDTH]
//   req_ready  [NUM_REQ]        one-hot grant (or zero)
//   resp_valid/resp_data/resp_id  output slot contents
//   resp_ready                  consumer accepts the slot
//   resp_borrow                 a < b flag (only with SUB_ARB_BORROW_EN)
// Modports: master = requesters + consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sub_arbiter_if
    import sub_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     resp_valid;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_ready;
`ifdef SUB_ARB_BORROW_EN
    logic                     resp_borrow;
`endif

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_id,
`ifdef SUB_ARB_BORROW_EN
        input  resp_borrow,
`endif
        output resp_ready
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_id,
`ifdef SUB_ARB_BORROW_EN
        output resp_borrow,
`endif
        input  resp_ready
    );

endinterface : sub_arbiter_if

// File: rtl/sub_unit.sv
// -----------------------------------------------------------------------------
// sub_unit
// Purely combinational WIDTH-bit unsigned subtractor.
//   a_i      : minuend
//   b_i      : subtrahend
//   diff_o   : a_i - b_i modulo 2^WIDTH
//   borrow_o : high when a_i < b_i (unsigned)
// -----------------------------------------------------------------------------
module sub_unit #(
    parameter int WIDTH = sub_arb_pkg::WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    // One extra bit on the left catches the borrow out of the MSB.
    logic [WIDTH:0] full_diff;

    assign full_diff = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o    = full_diff[WIDTH-1:0];
    assign borrow_o  = full_diff[WIDTH];

endmodule : sub_unit

// File: rtl/sub_arbiter.sv
// -----------------------------------------------------------------------------
// sub_arbiter
// Round-robin arbiter sharing one subtractor among NUM_REQ requesters. The
// winner's a - b is registered into a single output slot, tagged with the
// requester id, and held until the consumer accepts it. A new result may be
// loaded in the same cycle the old one drains, so throughput is one per cycle.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, synchronous release
//   bus   : sub_arbiter_if.slave (request / response handshakes)
//
// Optional feature (macro SUB_ARB_BORROW_EN): adds bus.resp_borrow, a register
// loaded with (a < b) on each transfer and held alongside resp_data.
// -----------------------------------------------------------------------------
module sub_arbiter
    import sub_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic          clock,
    input  logic          reset,
    sub_arbiter_if.slave  bus
);

    localparam int              ID_W    = id_width(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    slot_state_t      state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic             can_accept;
    logic             transfer;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH-1:0] diff;
    int               idx;

`ifdef SUB_ARB_BORROW_EN
    logic             borrow_q, borrow_d;
    logic             sub_borrow;
`else
    logic             unused_borrow;
`endif

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after ptr, wrapping.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default at
    // the top so no path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // The slot can take a new result if it is free or is being drained now.
    // Grants are suppressed while reset is held so nothing is handshaken away.
    assign can_accept = (state_q == EMPTY) || bus.resp_ready;
    assign transfer   = found && can_accept && reset;

    always_comb begin
        bus.req_ready = '0;
        if (transfer) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Shared subtractor, fed by the winner's operands. Its result only reaches
    // the outputs through the slot register.
    // -------------------------------------------------------------------------
    assign a_sel = bus.req_a[int'(winner)*WIDTH +: WIDTH];
    assign b_sel = bus.req_b[int'(winner)*WIDTH +: WIDTH];

    sub_unit #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i      (a_sel),
        .b_i      (b_sel),
        .diff_o   (diff),
`ifdef SUB_ARB_BORROW_EN
        .borrow_o (sub_borrow)
`else
        .borrow_o (unused_borrow)
`endif
    );

    // -------------------------------------------------------------------------
    // Slot FSM: next state and slot contents.
    // A transfer always loads the slot (covers both EMPTY and drain-and-reload
    // in FULL); a drain without a transfer frees it but keeps the old data so
    // resp_data never goes unknown.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        data_d  = data_q;
`ifdef SUB_ARB_BORROW_EN
        borrow_d = borrow_q;
`endif
        if (transfer) begin
            state_d = FULL;
            data_d  = diff;
            id_d    = winner;
            ptr_d   = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
`ifdef SUB_ARB_BORROW_EN
            borrow_d = sub_borrow;
`endif
        end else if ((state_q == FULL) && bus.resp_ready) begin
            state_d = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

`ifdef SUB_ARB_BORROW_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= borrow_d;
        end
    end

    assign bus.resp_borrow = borrow_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs straight from the slot registers.
    // -------------------------------------------------------------------------
    assign bus.resp_valid = (state_q == FULL);
    assign bus.resp_data  = data_q;
    assign bus.resp_id    = id_q;

endmodule : sub_arbiter

// File: tb/tb_sub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sub_arbiter
// Self-checking bench for sub_arbiter (NUM_REQ=4, WIDTH=8). A behavioural
// model of the slot (one optional entry plus a round-robin pointer) is
// checked against the DUT on every falling edge; directed scenarios add
// literal expectations. Honours SUB_ARB_BORROW_EN.
// -----------------------------------------------------------------------------
module tb_sub_arbiter;
    import sub_arb_pkg::*;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int ID_W = id_width(N);

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    sub_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    sub_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: the slot is either empty or holds one result; the
    // pointer names the requester with first claim on the next grant.
    // ---------------------------------------------------------------------
    bit         m_full   = 1'b0;
    logic [W-1:0] m_data = '0;
    int         m_id     = 0;
    bit         m_borrow = 1'b0;
    int         m_ptr    = 0;
    int         win;
    int         cand;
    bit         can;
    logic [N-1:0] exp_ready;
    logic [W-1:0] ma, mb;

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_resp_valid", bus.resp_valid, 0);
            m_full = 1'b0;
            m_data = '0;
            m_id   = 0;
            m_ptr  = 0;
            m_borrow = 1'b0;
        end else begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                cand = (m_ptr + k) % N;
                if (win < 0 && bus.req_valid[cand]) win = cand;
            end
            can = !m_full || bus.resp_ready;
            exp_ready = '0;
            if (win >= 0 && can) exp_ready[win] = 1'b1;

            check("req_ready", bus.req_ready, exp_ready);
            check("resp_valid", bus.resp_valid, m_full);
            check("data_known", $isunknown(bus.resp_data), 0);
            if (m_full) begin
                check("resp_data", bus.resp_data, m_data);
                check("resp_id", bus.resp_id, m_id);
`ifdef SUB_ARB_BORROW_EN
                check("resp_borrow", bus.resp_borrow, m_borrow);
`endif
            end

            if (win >= 0 && can) begin
                ma       = bus.req_a[win*W +: W];
                mb       = bus.req_b[win*W +: W];
                m_data   = W'((int'(ma) - int'(mb) + 256) % 256);
                m_borrow = (ma < mb);
                m_id     = win;
                m_full   = 1'b1;
                m_ptr    = (win + 1) % N;
            end else if (m_full && bus.resp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus with literal expectations.
    // ---------------------------------------------------------------------
    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        // Reset values, with requests present to show no grant leaks out.
        bus.req_valid = 4'hF;
        repeat (2) @(posedge clock);
        #2;
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_resp_valid", bus.resp_valid, 0);
        check("reset_resp_data", bus.resp_data, 0);
        check("reset_resp_id", bus.resp_id, 0);
`ifdef SUB_ARB_BORROW_EN
        check("reset_resp_borrow", bus.resp_borrow, 0);
`endif
        next_cycle();
        reset = 1'b1;
        bus.req_valid = '0;

        // Single request from requester 2.
        next_cycle();
        set_op(2, 8'h30, 8'h10);
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 1'b1;
        #1 check("t1_grant", bus.req_ready, 4'b0100);

        // All valid: result of req 2 visible, pointer now at 3.
        next_cycle();
        for (int i = 0; i < N; i++) set_op(i, W'(8'h10 * (i + 1)), W'(i));
        bus.req_valid = 4'hF;
        #1;
        check("t1_resp_valid", bus.resp_valid, 1);
        check("t1_resp_data", bus.resp_data, 8'h20);
        check("t1_resp_id", bus.resp_id, 2);
        check("t1_ptr_grant", bus.req_ready, 4'b1000);

        // Fairness: continuous requests, one result per cycle.
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            #1;
            check("fair_grant", bus.req_ready, 32'(1) << ((3 + c) % 4));
            check("fair_id", bus.resp_id, (3 + c - 1) % 4);
            check("fair_valid", bus.resp_valid, 1);
        end

        // Wrap-around subtraction.
        next_cycle();
        set_op(0, 8'h00, 8'h01);
        bus.req_valid = 4'b0001;
        #1 check("wrap_grant", bus.req_ready, 4'b0001);
        next_cycle();
        bus.req_valid = '0;
        #1;
        check("wrap_data", bus.resp_data, 8'hFF);
        check("wrap_id", bus.resp_id, 0);
`ifdef SUB_ARB_BORROW_EN
        check("wrap_borrow", bus.resp_borrow, 1);
`endif

        // Backpressure: fill slot from req 2 (ptr -> 3) with resp_ready low.
        next_cycle();
        set_op(2, 8'h55, 8'h12);
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 1'b0;
        next_cycle();
        set_op(1, 8'h80, 8'h7F);
        set_op(3, 8'h99, 8'h11);
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.req_valid = 4'b0010;  // requester 3 withdraws
            #1;
            check("bp_no_grant", bus.req_ready, 0);
            check("bp_data_hold", bus.resp_data, 8'h43);
            check("bp_valid", bus.resp_valid, 1);
            next_cycle();
        end
        // Drain and reload in the same cycle; req 3 left no trace.
        bus.resp_ready = 1'b1;
        #1 check("reload_grant", bus.req_ready, 4'b0010);
        next_cycle();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        #1;
        check("reload_valid", bus.resp_valid, 1);
        check("reload_id", bus.resp_id, 1);
        check("reload_data", bus.resp_data, 8'h01);

        // Mid-operation asynchronous reset with the slot full.
        @(posedge clock);
        #3;
        reset = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        check("mid_rst_valid", bus.resp_valid, 0);
        check("mid_rst_ready", bus.req_ready, 0);
        next_cycle();
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        #1 check("post_rst_grant", bus.req_ready, 4'b0001);
        next_cycle();
        bus.req_valid = '0;
        #1;
        check("post_rst_id", bus.resp_id, 0);
        check("post_rst_data", bus.resp_data, 8'hFF);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            bus.req_valid  = N'($urandom_range(0, 15));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) set_op(i, 8'h00, W'($urandom_range(1, 255)));
                else set_op(i, W'($urandom), W'($urandom));
            end
        end

        next_cycle();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sub_arbiter
